// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB constants: requester indices, the reserved "no station" tag and
// default widths agreed with the issue stage and reservation stations.
package cdb_arbiter_pkg;

    localparam int CdbAdd   = 0;
    localparam int CdbMul   = 1;
    localparam int CdbMem   = 2;
    localparam int CdbNreq  = 3;

    localparam int TagNone  = 0;
    localparam int CdbTagW  = 5;
    localparam int CdbDataW = 32;

    // Round-robin successor of idx in 0..n-1; n need not be a power of two.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index searching from
// i_ptr upward modulo NREQ. Shared by CDB and issue-port arbitration.
module cdb_arbiter_rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_eligible,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_idx,
    output logic            o_any_grant
);

    // One extra bit so ptr + offset never wraps before the modulo fold.
    logic [PW:0] w_sum;

    always_comb begin
        o_grant     = '0;
        o_idx       = '0;
        o_any_grant = 1'b0;
        w_sum       = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NREQ)) begin
                w_sum = w_sum - (PW+1)'(NREQ);
            end
            if (!o_any_grant && i_eligible[w_sum[PW-1:0]]) begin
                o_any_grant = 1'b1;
                o_idx       = w_sum[PW-1:0];
            end
        end
        o_grant[o_idx] = o_any_grant;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus owner: one holding slot per functional unit, round-robin
// pick each cycle, registered broadcast to stations and register status.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NREQ   = CdbNreq,
    parameter int TAG_W  = CdbTagW,
    parameter int DATA_W = CdbDataW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*TAG_W-1:0]    req_tag,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [$clog2(NREQ)-1:0]  cdb_src,
    output logic                     err_tag0
);

    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0]   r_hv;
    logic [TAG_W-1:0]  r_htag  [NREQ];
    logic [DATA_W-1:0] r_hdata [NREQ];
    logic [PW-1:0]     r_ptr;

    logic              r_cdb_valid;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_data;
    logic [PW-1:0]     r_cdb_src;
    logic              r_err_tag0;

    logic [NREQ-1:0]   w_eligible;
    logic [NREQ-1:0]   w_tag0;
    logic [NREQ-1:0]   w_grant;
    logic [NREQ-1:0]   w_take;
    logic [PW-1:0]     w_win;
    logic              w_any;
    logic [PW-1:0]     w_ptr_next;

    // Tag 0 means "no station": such entries are held one cycle, never granted.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_eligible[i] = r_hv[i] && (r_htag[i] != TAG_W'(TagNone));
        end
    end

    assign w_tag0 = r_hv & ~w_eligible;

    cdb_arbiter_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .i_eligible  (w_eligible),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_idx       (w_win),
        .o_any_grant (w_any)
    );

    // A slot being broadcast this cycle may refill at the same edge.
    assign req_ready  = {NREQ{!flush}} & (~r_hv | w_grant);
    assign w_take     = req_valid & req_ready;
    assign w_ptr_next = PW'(rr_next(int'(w_win), NREQ));

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (w_take[i]) begin
                r_htag[i]  <= req_tag[i*TAG_W +: TAG_W];
                r_hdata[i] <= req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hv        <= '0;
            r_ptr       <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_cdb_src   <= '0;
            r_err_tag0  <= 1'b0;
        end else if (flush) begin
            r_hv        <= '0;
            r_cdb_valid <= 1'b0;
            r_err_tag0  <= 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_take[i]) begin
                    r_hv[i] <= 1'b1;
                end else if (w_grant[i] || w_tag0[i]) begin
                    r_hv[i] <= 1'b0;
                end
            end
            r_err_tag0  <= |w_tag0;
            r_cdb_valid <= w_any;
            if (w_any) begin
                r_cdb_tag  <= r_htag[w_win];
                r_cdb_data <= r_hdata[w_win];
                r_cdb_src  <= w_win;
                r_ptr      <= w_ptr_next;
            end
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_data  = r_cdb_data;
    assign cdb_src   = r_cdb_src;
    assign err_tag0  = r_err_tag0;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios push expected CDB
// words into a queue; a negedge monitor pops and compares each broadcast.
module tb_cdb_arbiter;

    localparam int NREQ   = 3;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;
    localparam int SW     = 2;
    localparam int W      = SW + TAG_W + DATA_W;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*TAG_W-1:0]   req_tag;
    logic [NREQ*DATA_W-1:0]  req_data;
    logic [NREQ-1:0]         req_ready;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;
    logic [SW-1:0]           cdb_src;
    logic                    err_tag0;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_err_pulses = 0;

    cdb_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src),
        .err_tag0  (err_tag0)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_tag   = '0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [TAG_W-1:0] t,
                           input logic [DATA_W-1:0] d);
        req_valid[i]                 = v;
        req_tag[i*TAG_W +: TAG_W]    = t;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic push_exp(input logic [SW-1:0] s, input logic [TAG_W-1:0] t,
                            input logic [DATA_W-1:0] d);
        exp_q.push_back({s, t, d});
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (err_tag0) n_err_pulses++;
        if (cdb_valid) begin
            if (exp_q.size() == 0) begin
                check("cdb_unexpected", {cdb_src, cdb_tag, cdb_data}, 64'd0);
            end else begin
                check("cdb_word", {cdb_src, cdb_tag, cdb_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [DATA_W-1:0] d0, d1, d2, d3, d4;
        int err_base;

        // Reset then idle
        do_reset();
        repeat (10) begin
            @(negedge clk);
            check("idle_valid", 64'(cdb_valid), 64'd0);
            check("idle_ready", 64'(req_ready), 64'b111);
            check("idle_tag", 64'(cdb_tag), 64'd0);
            step();
        end

        // Single Mul result
        set_req(1, 1'b1, 5'd5, 32'h0000_00AA);
        push_exp(2'd1, 5'd5, 32'h0000_00AA);
        @(negedge clk);
        check("single_ready", 64'(req_ready[1]), 64'd1);
        step();
        req_valid = '0;
        @(negedge clk);
        check("single_e0_valid", 64'(cdb_valid), 64'd0);
        step();
        @(negedge clk);
        check("single_e1_valid", 64'(cdb_valid), 64'd1);
        step();
        @(negedge clk);
        check("single_e2_valid", 64'(cdb_valid), 64'd0);
        wait_drain("single_drain");

        // Reset clears the output registers left by the previous broadcast
        do_reset();
        @(negedge clk);
        check("rst_tag", 64'(cdb_tag), 64'd0);
        check("rst_data", 64'(cdb_data), 64'd0);
        check("rst_src", 64'(cdb_src), 64'd0);
        check("rst_err", 64'(err_tag0), 64'd0);
        step();

        // Round-robin fairness: every unit refills right after each accept
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'hA000_0000 | 32'(i + 1));
        for (int i = 0; i < NREQ; i++) push_exp(2'(i), 5'(i + 1), 32'hA000_0000 | 32'(i + 1));
        for (int i = 0; i < NREQ; i++) push_exp(2'(i), 5'(i + 1), 32'hB000_0000 | 32'(i + 1));
        @(negedge clk);
        check("rr_ready_e0", 64'(req_ready), 64'b111);
        step();
        for (int i = 0; i < NREQ; i++) req_data[i*DATA_W +: DATA_W] = 32'hB000_0000 | 32'(i + 1);
        @(negedge clk);
        check("rr_ready_e1", 64'(req_ready), 64'b001);
        step();
        req_valid = 3'b110;
        @(negedge clk);
        check("rr_ready_e2", 64'(req_ready), 64'b010);
        check("rr_valid_1", 64'(cdb_valid), 64'd1);
        step();
        req_valid = 3'b100;
        @(negedge clk);
        check("rr_ready_e3", 64'(req_ready), 64'b100);
        check("rr_valid_2", 64'(cdb_valid), 64'd1);
        step();
        req_valid = 3'b000;
        for (int k = 3; k <= 6; k++) begin
            @(negedge clk);
            check("rr_valid_n", 64'(cdb_valid), 64'(k <= 6 && k >= 3));
            step();
        end
        @(negedge clk);
        check("rr_valid_end", 64'(cdb_valid), 64'd0);
        wait_drain("rr_drain");

        // Back-to-back stream from Add
        do_reset();
        set_req(0, 1'b1, 5'd4, 32'hC000_0004);
        push_exp(2'd0, 5'd4, 32'hC000_0004);
        push_exp(2'd0, 5'd6, 32'hC000_0006);
        push_exp(2'd0, 5'd7, 32'hC000_0007);
        @(negedge clk);
        check("b2b_ready_0", 64'(req_ready[0]), 64'd1);
        step();
        set_req(0, 1'b1, 5'd6, 32'hC000_0006);
        @(negedge clk);
        check("b2b_ready_1", 64'(req_ready[0]), 64'd1);
        step();
        set_req(0, 1'b1, 5'd7, 32'hC000_0007);
        @(negedge clk);
        check("b2b_ready_2", 64'(req_ready[0]), 64'd1);
        check("b2b_valid_1", 64'(cdb_valid), 64'd1);
        step();
        req_valid = '0;
        repeat (2) begin
            @(negedge clk);
            check("b2b_valid_n", 64'(cdb_valid), 64'd1);
            step();
        end
        @(negedge clk);
        check("b2b_valid_end", 64'(cdb_valid), 64'd0);
        wait_drain("b2b_drain");

        // Tag-0 discard on the Mem slot
        do_reset();
        err_base = n_err_pulses;
        set_req(0, 1'b1, 5'd9, 32'h0000_0909);
        set_req(2, 1'b1, 5'd0, 32'hFFFF_FFFF);
        push_exp(2'd0, 5'd9, 32'h0000_0909);
        @(negedge clk);
        check("t0_ready_e0", 64'(req_ready), 64'b111);
        step();
        req_valid = '0;
        @(negedge clk);
        check("t0_ready_e1", 64'(req_ready), 64'b011);
        check("t0_err_e1", 64'(err_tag0), 64'd0);
        step();
        @(negedge clk);
        check("t0_err_e2", 64'(err_tag0), 64'd1);
        check("t0_ready_e2", 64'(req_ready), 64'b111);
        step();
        @(negedge clk);
        check("t0_err_e3", 64'(err_tag0), 64'd0);
        wait_drain("t0_drain");
        repeat (2) step();
        check("t0_err_count", 64'(n_err_pulses - err_base), 64'd1);

        // Flush mid-stream, then ptr continues from its pre-flush value
        do_reset();
        d0 = $urandom; d1 = $urandom; d2 = $urandom;
        d3 = $urandom; d4 = 32'($urandom_range(1, 1000));
        set_req(0, 1'b1, 5'd10, d0);
        set_req(1, 1'b1, 5'd11, d1);
        set_req(2, 1'b1, 5'd12, d2);
        push_exp(2'd0, 5'd10, d0);
        step();
        req_valid = '0;
        @(negedge clk);
        check("fl_valid_e0", 64'(cdb_valid), 64'd0);
        step();
        flush = 1'b1;
        set_req(1, 1'b1, 5'd13, d3);
        @(negedge clk);
        check("fl_ready", 64'(req_ready), 64'b000);
        check("fl_first_valid", 64'(cdb_valid), 64'd1);
        step();
        flush     = 1'b0;
        req_valid = '0;
        repeat (4) begin
            @(negedge clk);
            check("fl_idle_valid", 64'(cdb_valid), 64'd0);
            step();
        end
        wait_drain("fl_drain_a");
        set_req(0, 1'b1, 5'd14, d3);
        set_req(2, 1'b1, 5'd15, d4);
        push_exp(2'd2, 5'd15, d4);
        push_exp(2'd0, 5'd14, d3);
        step();
        req_valid = '0;
        wait_drain("fl_drain_b");
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Owns the Common Data Bus (CDB) in the Tomasulo core.
- Each functional unit (Add, Mul/Div, Load) completes a result and hands the unit a {station tag, data} pair.
- The unit buffers one result per requester, picks one per cycle round-robin, and broadcasts it as a registered CDB write.
- Reservation stations and the register-status table snoop that broadcast.

Parameters:
- NREQ, 3, number of requesting functional units (index 0=Add, 1=Mul/Div, 2=Mem load).
- TAG_W, 5, reservation-station tag width; must match the issue stage's station-number width.
- DATA_W, 32, result data width.

Ports:
- clk, in, 1, system clock; all state updates on rising edge.
- rst, in, 1, synchronous active-high reset.
- flush, in, 1, synchronous squash of all buffered and outgoing results (jump/mispredict recovery).
- req_valid, in, NREQ, per-requester result-valid.
- req_tag, in, NREQ*TAG_W, packed per-requester station tags; requester i occupies bits [i*TAG_W +: TAG_W].
- req_data, in, NREQ*DATA_W, packed per-requester results.
- req_ready, out, NREQ, per-requester accept; a transfer occurs when req_valid[i]&&req_ready[i] at a rising edge.
- cdb_valid, out, 1, registered broadcast valid.
- cdb_tag, out, TAG_W, registered broadcast tag.
- cdb_data, out, DATA_W, registered broadcast data.
- cdb_src, out, $clog2(NREQ), registered index of the requester that won.
- err_tag0, out, 1, registered one-cycle pulse when a result carrying reserved tag 0 is discarded.

Behaviour:
- State:
  - One holding register per requester: hv[i], htag[i], hdata[i].
  - Round-robin pointer ptr (0..NREQ-1).
  - The output registers.
- Reset (rst=1 at edge):
  - hv=0, ptr=0.
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, err_tag0=0.
  - rst has priority over flush and all requests.
- req_ready[i] = !flush && (!hv[i] || grant[i]); this is combinational. A slot granted this cycle can refill at the same edge, giving full throughput.
- Accept: on a transfer edge, hv[i]<=1 and htag/hdata capture the inputs.
- Tag 0 is reserved as "no station":
  - An entry with htag=0 is never granted.
  - It is dropped in the cycle after capture (hv<=0 unless refilled), and err_tag0<=1 for one cycle.
  - Such entries take no CDB slot.
- Arbitration:
  - Combinational over eligible entries, eligible[i]=hv[i]&&htag[i]!=0.
  - The first eligible index, searching ptr, ptr+1, … modulo NREQ, wins.
  - At most one grant per cycle.
- Broadcast:
  - If a grant exists, at the next edge cdb_valid<=1, cdb_tag/cdb_data<=winner's holding contents, cdb_src<=winner, hv[winner]<=0 (unless refilled), ptr<=(winner+1) mod NREQ.
  - With no grant, cdb_valid<=0, tag/data/src hold their values, and ptr is unchanged.
- Latency: a result accepted at edge E0 appears on the CDB after edge E1 at the earliest. Worst case is NREQ edges after E0 while all requesters are continuously busy. No starvation under round-robin.
- cdb_valid is a single-cycle pulse per result; there is no backpressure from consumers.
- Flush (flush=1, rst=0 at edge):
  - All hv<=0, cdb_valid<=0, err_tag0<=0, ptr unchanged.
  - req_ready=0 during the flush cycle, so no request is accepted.
  - A grant computed in the flush cycle is suppressed.
- Simultaneous refill and grant of the same slot: the new data is stored and the old data is broadcast, with no loss.
- All arithmetic on ptr is modulo NREQ; NREQ need not be a power of two.

Decomposition:
- The shared header carries:
  - requester index constants (`CdbAdd 0, `CdbMul 1, `CdbMem 2);
  - `TagNone 0;
  - default TAG_W/DATA_W values shared with the issue stage and reservation stations.
- One natural sub-module: rr_pick (combinational). Inputs eligible[NREQ] and ptr; outputs a one-hot grant and the winner index plus any_grant. It is reused later for issue-port arbitration.

Test Plan:
- Reset then idle:
  - rst=1 for 2 cycles, then release with all req_valid=0 → cdb_valid=0, req_ready=3'b111, cdb_tag=0 for 10 cycles.
- Single result:
  - Mul presents tag=5, data=32'h0000_00AA at edge E0 → cdb_valid=1, cdb_tag=5, cdb_data=AA, cdb_src=1 after E1.
  - cdb_valid=0 after E2.
- Round-robin fairness:
  - All three hold valid continuously with tags 1, 2, 3 (refilled each accept).
  - CDB sequence of tags is 1, 2, 3, 1, 2, 3, one per cycle, with no idle cycles after the first.
- Back-to-back same requester:
  - Add streams tags 4, 6, 7 on consecutive edges while others are idle.
  - req_ready[0] stays 1 and the CDB shows 4, 6, 7 on consecutive cycles.
- Tag-0 discard:
  - Mem presents tag=0, data=FFFF_FFFF while Add presents tag 9.
  - Only tag 9 is broadcast, err_tag0 pulses once, and the Mem slot frees within one cycle.
- Flush mid-stream:
  - All three hold results; assert flush for one cycle after the first broadcast.
  - cdb_valid=0 the next cycle, no further broadcasts, and req_ready=0 during the flush cycle.
  - A fresh request after the flush broadcasts normally, with ptr continuing from its pre-flush value.
